segment_write_arbiter: RTL and testbench

Shares the single write port of the segment register file (CS/DS/SS/ES) among three requesters:
- requester 0: control-transfer/interrupt CS loader
- requester 1: execution unit (MOV/POP Sreg)
- requester 2: debug/config port

It registers the winning request, drives write_en/reg_select/data to the segment file, and pulses a prefetch-queue flush on CS writes. It also generates the post-SS-write interrupt-inhibit window.

---
 rtl/segment_write_arbiter_if.sv | 29 ++
 rtl/segment_write_arbiter.sv | 154 +++++++++++++++
 tb/tb_segment_write_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/segment_write_arbiter_if.sv
// Segment file write-port bundle: three requesters in, one registered write out.
interface segment_write_arbiter_if #(
  parameter int DATA_W = 16
);
  logic [2:0]          req;
  logic [5:0]          req_sel;
  logic [3*DATA_W-1:0] req_data;
  logic                lock_cfg;
  logic                instr_done;
  logic [2:0]          gnt;
  logic                write_en;
  logic [1:0]          reg_select;
  logic [DATA_W-1:0]   data;
  logic                queue_flush;
  logic                int_inhibit;
  logic                busy;

  // Requester / EU side
  modport master (
    output req, req_sel, req_data, lock_cfg, instr_done,
    input  gnt, write_en, reg_select, data, queue_flush, int_inhibit, busy
  );

  // Arbiter side
  modport slave (
    input  req, req_sel, req_data, lock_cfg, instr_done,
    output gnt, write_en, reg_select, data, queue_flush, int_inhibit, busy
  );
endinterface

// File: rtl/segment_write_arbiter.sv
// Arbitrates the single segment register file write port between the CS
// loader (0), the execution unit (1) and the debug/config port (2). Every
// write takes one registered WRITE cycle; an SS write opens an interrupt
// inhibit window that lasts until two further instructions complete.
module segment_write_arbiter #(
  parameter bit RR_LOW = 1'b1,
  parameter int DATA_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  segment_write_arbiter_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t              state_reg, state_next;

  logic [1:0]          sel_arr  [3];
  logic [DATA_W-1:0]   data_arr [3];

  logic [2:0]          eligible;
  logic [1:0]          win_idx;
  logic                capture;

  logic                rr_fav2_reg, rr_fav2_next;
  logic [2:0]          gnt_reg, gnt_next;
  logic                write_en_reg, write_en_next;
  logic [1:0]          reg_select_reg, reg_select_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                queue_flush_reg, queue_flush_next;
  logic                busy_reg, busy_next;
  logic                int_inhibit_reg, int_inhibit_next;
  logic [1:0]          inh_cnt_reg, inh_cnt_next;

  // Split the packed per-requester select/data buses into indexable arrays
  for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
    assign sel_arr[gi]  = bus.req_sel[2*gi +: 2];
    assign data_arr[gi] = bus.req_data[gi*DATA_W +: DATA_W];
  end

  // Winner selection: CS loader first, then EU vs debug by rr pointer or fixed
  always_comb begin
    eligible = bus.req & {~bus.lock_cfg, 2'b11};
    win_idx  = 2'd0;
    if (eligible[0]) begin
      win_idx = 2'd0;
    end else if (eligible[1] && eligible[2]) begin
      win_idx = (RR_LOW && rr_fav2_reg) ? 2'd2 : 2'd1;
    end else if (eligible[1]) begin
      win_idx = 2'd1;
    end else begin
      win_idx = 2'd2;
    end
    capture = (state_reg == IDLE) && (eligible != 3'b000);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a capture in IDLE commits to exactly one WRITE cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (capture) state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output next-values: grant/strobe only in the cycle following a capture
  always_comb begin
    gnt_next         = 3'b000;
    write_en_next    = 1'b0;
    busy_next        = 1'b0;
    queue_flush_next = 1'b0;
    reg_select_next  = reg_select_reg;
    data_next        = data_reg;
    rr_fav2_next     = rr_fav2_reg;
    if (capture) begin
      gnt_next         = 3'b001 << win_idx;
      write_en_next    = 1'b1;
      busy_next        = 1'b1;
      reg_select_next  = sel_arr[win_idx];
      data_next        = data_arr[win_idx];
      queue_flush_next = (sel_arr[win_idx] == 2'b00);
      // A CS-loader grant leaves the pointer alone
      if (RR_LOW) begin
        if (win_idx == 2'd1) begin
          rr_fav2_next = 1'b1;
        end else if (win_idx == 2'd2) begin
          rr_fav2_next = 1'b0;
        end
      end
    end
  end

  // Interrupt inhibit window: opened by an SS write, closed by the 2nd instr_done
  always_comb begin
    int_inhibit_next = int_inhibit_reg;
    inh_cnt_next     = inh_cnt_reg;
    if ((state_reg == WRITE) && (reg_select_reg == 2'b10)) begin
      // instr_done coinciding with the SS write belongs to an earlier instruction
      int_inhibit_next = 1'b1;
      inh_cnt_next     = 2'd0;
    end else if (int_inhibit_reg && bus.instr_done) begin
      if (inh_cnt_reg == 2'd1) begin
        int_inhibit_next = 1'b0;
        inh_cnt_next     = 2'd0;
      end else begin
        inh_cnt_next = inh_cnt_reg + 2'd1;
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_fav2_reg     <= 1'b0;
      gnt_reg         <= 3'b000;
      write_en_reg    <= 1'b0;
      reg_select_reg  <= 2'b00;
      data_reg        <= '0;
      queue_flush_reg <= 1'b0;
      busy_reg        <= 1'b0;
      int_inhibit_reg <= 1'b0;
      inh_cnt_reg     <= 2'd0;
    end else begin
      rr_fav2_reg     <= rr_fav2_next;
      gnt_reg         <= gnt_next;
      write_en_reg    <= write_en_next;
      reg_select_reg  <= reg_select_next;
      data_reg        <= data_next;
      queue_flush_reg <= queue_flush_next;
      busy_reg        <= busy_next;
      int_inhibit_reg <= int_inhibit_next;
      inh_cnt_reg     <= inh_cnt_next;
    end
  end

  assign bus.gnt         = gnt_reg;
  assign bus.write_en    = write_en_reg;
  assign bus.reg_select  = reg_select_reg;
  assign bus.data        = data_reg;
  assign bus.queue_flush = queue_flush_reg;
  assign bus.int_inhibit = int_inhibit_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_segment_write_arbiter.sv
// Bench for segment_write_arbiter: one round-robin and one fixed-priority
// instance share the same directed stimulus; a transaction-level model
// predicts every output each cycle, and literal expectations pin key points.
module tb_segment_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [5:0]  req_sel;
  logic [47:0] req_data;
  logic        lock_cfg;
  logic        instr_done;

  int errors = 0;
  int checks = 0;
  bit model_valid = 1'b0;

  always #5 clk = ~clk;

  segment_write_arbiter_if #(.DATA_W(16)) if_rr ();
  segment_write_arbiter_if #(.DATA_W(16)) if_fp ();

  assign if_rr.req = req;           assign if_fp.req = req;
  assign if_rr.req_sel = req_sel;   assign if_fp.req_sel = req_sel;
  assign if_rr.req_data = req_data; assign if_fp.req_data = req_data;
  assign if_rr.lock_cfg = lock_cfg; assign if_fp.lock_cfg = lock_cfg;
  assign if_rr.instr_done = instr_done;
  assign if_fp.instr_done = instr_done;

  segment_write_arbiter #(.RR_LOW(1'b1), .DATA_W(16)) u_rr (
    .clk(clk), .rst(rst), .bus(if_rr)
  );
  segment_write_arbiter #(.RR_LOW(1'b0), .DATA_W(16)) u_fp (
    .clk(clk), .rst(rst), .bus(if_fp)
  );

  // Model state per instance (0 = round-robin, 1 = fixed priority)
  bit          m_pending [2];  // a write was committed and is on the port now
  bit          m_fav2    [2];  // next 1-vs-2 tie goes to requester 2
  int          m_done    [2];  // instructions completed inside the window
  logic [2:0]  e_gnt     [2];
  logic        e_we      [2];
  logic [1:0]  e_sel     [2];
  logic [15:0] e_data    [2];
  logic        e_qf      [2];
  logic        e_inh     [2];
  logic        e_busy    [2];

  logic [2:0]  rr_seq [4] = '{3'b010, 3'b100, 3'b010, 3'b100};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic count_instr(input int k);
    m_done[k] = m_done[k] + 1;
    if (m_done[k] == 2) begin
      e_inh[k]  = 1'b0;
      m_done[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    logic [2:0] elig;
    int w;
    if (rst) begin
      m_pending[k] = 0; m_fav2[k] = 0; m_done[k] = 0;
      e_gnt[k] = 3'b000; e_we[k] = 0; e_sel[k] = 2'b00; e_data[k] = 16'h0;
      e_qf[k] = 0; e_inh[k] = 0; e_busy[k] = 0;
    end else if (m_pending[k]) begin
      if (e_sel[k] == 2'b10) begin
        e_inh[k]  = 1'b1;
        m_done[k] = 0;
      end else if (e_inh[k] && instr_done) begin
        count_instr(k);
      end
      m_pending[k] = 0;
      e_gnt[k] = 3'b000; e_we[k] = 0; e_qf[k] = 0; e_busy[k] = 0;
    end else begin
      if (e_inh[k] && instr_done) count_instr(k);
      elig = req & {~lock_cfg, 2'b11};
      e_gnt[k] = 3'b000; e_we[k] = 0; e_qf[k] = 0; e_busy[k] = 0;
      if (elig != 3'b000) begin
        if (elig[0]) w = 0;
        else if (elig[1] && elig[2]) w = ((k == 0) && m_fav2[k]) ? 2 : 1;
        else if (elig[1]) w = 1;
        else w = 2;
        if (w == 1) m_fav2[k] = 1;
        if (w == 2) m_fav2[k] = 0;
        m_pending[k] = 1;
        e_gnt[k]  = 3'(1 << w);
        e_we[k]   = 1'b1;
        e_busy[k] = 1'b1;
        e_sel[k]  = req_sel[2*w +: 2];
        e_data[k] = req_data[16*w +: 16];
        e_qf[k]   = (e_sel[k] == 2'b00);
      end
    end
  endtask

  task automatic check_inst(input int k, input string tag, input logic [2:0] g, input logic we,
                            input logic [1:0] s, input logic [15:0] d, input logic qf,
                            input logic inh, input logic b);
    chk({tag, ".gnt"},         32'(g),   32'(e_gnt[k]));
    chk({tag, ".write_en"},    32'(we),  32'(e_we[k]));
    chk({tag, ".reg_select"},  32'(s),   32'(e_sel[k]));
    chk({tag, ".data"},        32'(d),   32'(e_data[k]));
    chk({tag, ".queue_flush"}, 32'(qf),  32'(e_qf[k]));
    chk({tag, ".int_inhibit"}, 32'(inh), 32'(e_inh[k]));
    chk({tag, ".busy"},        32'(b),   32'(e_busy[k]));
  endtask

  // Advance the model at each edge using the inputs the DUT samples there
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) model_step(k);
    if (rst) model_valid = 1'b1;
  end

  // Compare both instances against the model on the opposite edge
  always @(negedge clk) begin
    if (model_valid) begin
      check_inst(0, "rr", if_rr.gnt, if_rr.write_en, if_rr.reg_select, if_rr.data,
                 if_rr.queue_flush, if_rr.int_inhibit, if_rr.busy);
      check_inst(1, "fp", if_fp.gnt, if_fp.write_en, if_fp.reg_select, if_fp.data,
                 if_fp.queue_flush, if_fp.int_inhibit, if_fp.busy);
      if (if_rr.write_en)
        $display("%0t write rr: gnt=%b sel=%b data=%h flush=%b", $time,
                 if_rr.gnt, if_rr.reg_select, if_rr.data, if_rr.queue_flush);
      if (if_fp.write_en)
        $display("%0t write fp: gnt=%b sel=%b data=%h flush=%b", $time,
                 if_fp.gnt, if_fp.reg_select, if_fp.data, if_fp.queue_flush);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 3'b000; req_sel = 6'b0; req_data = 48'h0;
    lock_cfg = 1'b0; instr_done = 1'b0;
    tick(); tick();
    chk("rst_write_en", 32'(if_rr.write_en), 32'd0);
    chk("rst_int_inhibit", 32'(if_rr.int_inhibit), 32'd0);
    rst = 1'b0;

    // CS load by requester 0
    req = 3'b001; req_sel = 6'b000000; req_data = {16'h0, 16'h0, 16'hF000};
    tick();
    chk("t1_gnt", 32'(if_rr.gnt), 32'b001);
    chk("t1_data", 32'(if_rr.data), 32'hF000);
    chk("t1_flush", 32'(if_rr.queue_flush), 32'd1);
    req = 3'b000;
    tick();
    chk("t1_busy_after", 32'(if_rr.busy), 32'd0);
    chk("t1_data_hold", 32'(if_rr.data), 32'hF000);

    // EU vs debug contention
    req = 3'b110; req_sel = 6'b110100; req_data = {16'h2222, 16'h1111, 16'h0};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_rr_gnt", 32'(if_rr.gnt), 32'(rr_seq[i]));
      chk("t2_fp_gnt", 32'(if_fp.gnt), 32'b010);
      tick();
      chk("t2_gap", 32'(if_rr.write_en), 32'd0);
    end
    req = 3'b000;
    tick();

    // All three at once: CS loader wins, DS select so no flush
    req = 3'b111; req_sel = 6'b110101; req_data = {16'h2222, 16'h1111, 16'h0AAA};
    tick();
    chk("t3_gnt", 32'(if_rr.gnt), 32'b001);
    chk("t3_flush", 32'(if_rr.queue_flush), 32'd0);
    req = 3'b000;
    tick();
    lock_cfg = 1'b1; req = 3'b100;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_locked", 32'(if_rr.write_en), 32'd0);
    end
    req = 3'b000; lock_cfg = 1'b0;
    tick();

    // SS write opens the inhibit window
    req = 3'b010; req_sel = 6'b001000; req_data = {16'h0, 16'h3000, 16'h0};
    tick();
    chk("t4_sel", 32'(if_rr.reg_select), 32'b10);
    chk("t4_inh_during", 32'(if_rr.int_inhibit), 32'd0);
    req = 3'b000;
    tick();
    chk("t4_inh_set", 32'(if_rr.int_inhibit), 32'd1);
    tick();
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    chk("t4_inh_pulse1", 32'(if_rr.int_inhibit), 32'd1);
    tick();
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    chk("t4_inh_pulse2", 32'(if_rr.int_inhibit), 32'd0);

    // Restart on second SS write; DS write in between is neutral
    req = 3'b010; req_data = {16'h0, 16'h3001, 16'h0};
    tick();
    req = 3'b000; instr_done = 1'b1;
    tick();
    instr_done = 1'b0;
    chk("t5_inh_set", 32'(if_rr.int_inhibit), 32'd1);
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    chk("t5_first_count", 32'(if_rr.int_inhibit), 32'd1);
    req = 3'b010; req_data = {16'h0, 16'h3002, 16'h0};
    tick();
    req = 3'b000;
    tick();
    req = 3'b010; req_sel = 6'b000100; req_data = {16'h0, 16'h0D00, 16'h0};
    tick();
    chk("t5_ds_sel", 32'(if_rr.reg_select), 32'b01);
    req = 3'b000;
    tick();
    chk("t5_ds_neutral", 32'(if_rr.int_inhibit), 32'd1);
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    chk("t5_restart_p1", 32'(if_rr.int_inhibit), 32'd1);
    instr_done = 1'b1; tick(); instr_done = 1'b0;
    chk("t5_restart_p2", 32'(if_rr.int_inhibit), 32'd0);

    // Reset during a WRITE voids it; held request re-granted afterwards
    req = 3'b001; req_sel = 6'b000010; req_data = {16'h0, 16'h0, 16'hF123};
    tick();
    chk("t6_we", 32'(if_rr.write_en), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_rst_we", 32'(if_rr.write_en), 32'd0);
    chk("t6_rst_data", 32'(if_rr.data), 32'h0);
    rst = 1'b0;
    tick();
    chk("t6_regrant", 32'(if_rr.gnt), 32'b001);
    req = 3'b000;
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
